// File: rtl/snoop_responder_pkg.sv
// Shared cache types for the snoop responder: MESI encoding, snoop op/result
// encodings and default cache geometry.
package snoop_responder_pkg;

  localparam int DEF_D_WAYS    = 8;
  localparam int DEF_SETS      = 16384;
  localparam int DEF_TAG_WIDTH = 12;
  localparam int LINE_OFS      = 6;

  typedef enum logic [1:0] {
    MESI_M = 2'd0,
    MESI_E = 2'd1,
    MESI_S = 2'd2,
    MESI_I = 2'd3
  } mesi_state_t;

  typedef enum logic [1:0] {
    SNP_READ       = 2'd0,
    SNP_WRITE      = 2'd1,
    SNP_RWIM       = 2'd2,
    SNP_INVALIDATE = 2'd3
  } snoop_op_t;

  typedef enum logic [1:0] {
    RSP_HIT   = 2'd0,
    RSP_HITM  = 2'd1,
    RSP_NOHIT = 2'd2
  } snoop_rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_COMPARE = 3'd2,
    ST_WB      = 3'd3,
    ST_UPDATE  = 3'd4,
    ST_RESP    = 3'd5
  } snp_fsm_t;

endpackage

// File: rtl/snoop_responder_way_match.sv
// Combinational priority hit detector: a way hits when its tag matches and its
// state is not Invalid; the lowest-indexed hitting way wins.
module snoop_way_match
  import snoop_responder_pkg::*;
#(
  parameter int D_WAYS    = DEF_D_WAYS,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
  input  logic [D_WAYS*TAG_WIDTH-1:0] i_tags,
  input  logic [D_WAYS*2-1:0]         i_states,
  input  logic [TAG_WIDTH-1:0]        i_tag,
  output logic                        o_hit,
  output logic [$clog2(D_WAYS)-1:0]   o_way,
  output mesi_state_t                 o_state
);

  localparam int WAY_W = $clog2(D_WAYS);

  logic [D_WAYS-1:0] w_way_hit;
  mesi_state_t       w_way_state [D_WAYS];

  genvar gi;
  generate
    for (gi = 0; gi < D_WAYS; gi++) begin : g_way
      assign w_way_state[gi] = mesi_state_t'(i_states[gi*2 +: 2]);
      assign w_way_hit[gi]   = (i_tags[gi*TAG_WIDTH +: TAG_WIDTH] == i_tag) &&
                               (w_way_state[gi] != MESI_I);
    end
  endgenerate

  // Scan from the top down so the lowest hitting way is the last one written.
  always_comb begin
    o_hit   = 1'b0;
    o_way   = '0;
    o_state = MESI_I;
    for (int i = D_WAYS - 1; i >= 0; i--) begin
      if (w_way_hit[i]) begin
        o_hit   = 1'b1;
        o_way   = WAY_W'(i);
        o_state = w_way_state[i];
      end
    end
  end

endmodule

// File: rtl/snoop_responder.sv
// Snoop responder for the L1 data cache: looks up the snooped set, reports
// HIT/HITM/NOHIT, requests writeback of Modified data and updates MESI state.
module snoop_responder
  import snoop_responder_pkg::*;
#(
  parameter int D_WAYS    = DEF_D_WAYS,
  parameter int SETS      = DEF_SETS,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH,
  parameter int CNT_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          snp_valid,
  output logic                          snp_ready,
  input  logic [1:0]                    snp_op,
  input  logic [31:0]                   snp_addr,
  output logic                          tag_rd_en,
  output logic [$clog2(SETS)-1:0]       tag_rd_set,
  input  logic [D_WAYS*TAG_WIDTH-1:0]   tag_rd_tag,
  input  logic [D_WAYS*2-1:0]           tag_rd_state,
  output logic                          st_wr_en,
  output logic [$clog2(SETS)-1:0]       st_wr_set,
  output logic [$clog2(D_WAYS)-1:0]     st_wr_way,
  output logic [1:0]                    st_wr_state,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [31:0]                   wb_addr,
  output logic [$clog2(D_WAYS)-1:0]     wb_way,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [1:0]                    rsp_result,
  output logic                          busy,
  output logic                          proto_err,
  output logic [CNT_W-1:0]              hit_cnt,
  output logic [CNT_W-1:0]              hitm_cnt,
  output logic [CNT_W-1:0]              nohit_cnt
);

  localparam int SET_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(D_WAYS);
  localparam int LINE_W = 32 - LINE_OFS;

  snp_fsm_t          r_state, w_state_next;
  snoop_op_t         r_op;
  logic [LINE_W-1:0] r_line;
  logic [WAY_W-1:0]  r_way;
  mesi_state_t       r_new_state;
  snoop_rsp_t        r_result;
  logic              r_change;
  logic [CNT_W-1:0]  r_hit_cnt, r_hitm_cnt, r_nohit_cnt;

  logic              w_accept;
  logic              w_unused_ofs;
  logic [SET_W-1:0]  w_set;
  logic [TAG_WIDTH-1:0] w_tag;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  mesi_state_t       w_hit_state;
  mesi_state_t       w_new_state;
  snoop_rsp_t        w_result;
  logic              w_needs_wb;
  logic              w_proto;
  logic              w_change;

  assign w_accept     = snp_valid && snp_ready;
  assign w_unused_ofs = ^snp_addr[LINE_OFS-1:0];
  assign w_set        = r_line[SET_W-1:0];
  assign w_tag        = r_line[LINE_W-1 -: TAG_WIDTH];

  snoop_way_match #(
    .D_WAYS    (D_WAYS),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_way_match (
    .i_tags   (tag_rd_tag),
    .i_states (tag_rd_state),
    .i_tag    (w_tag),
    .o_hit    (w_hit),
    .o_way    (w_hit_way),
    .o_state  (w_hit_state)
  );

  // Per-op MESI transition; evaluated while the read data is valid in COMPARE.
  always_comb begin
    w_result    = RSP_NOHIT;
    w_new_state = w_hit_state;
    w_needs_wb  = 1'b0;
    w_proto     = 1'b0;
    if (w_hit) begin
      case (r_op)
        SNP_READ: begin
          w_new_state = MESI_S;
          w_needs_wb  = (w_hit_state == MESI_M);
          w_result    = (w_hit_state == MESI_M) ? RSP_HITM : RSP_HIT;
        end
        SNP_RWIM: begin
          w_new_state = MESI_I;
          w_needs_wb  = (w_hit_state == MESI_M);
          w_result    = (w_hit_state == MESI_M) ? RSP_HITM : RSP_HIT;
        end
        SNP_INVALIDATE: begin
          w_result = RSP_HIT;
          if (w_hit_state == MESI_S) begin
            w_new_state = MESI_I;
          end else begin
            w_proto = 1'b1;
          end
        end
        default: begin
          w_proto = 1'b1;
        end
      endcase
    end
    w_change = w_hit && (w_new_state != w_hit_state);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_next = ST_LOOKUP;
      ST_LOOKUP:  w_state_next = ST_COMPARE;
      ST_COMPARE: w_state_next = w_needs_wb ? ST_WB : ST_UPDATE;
      ST_WB:      if (wb_ready) w_state_next = ST_UPDATE;
      ST_UPDATE:  w_state_next = ST_RESP;
      ST_RESP:    if (rsp_ready) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    snp_ready = 1'b0;
    busy      = 1'b1;
    tag_rd_en = 1'b0;
    proto_err = 1'b0;
    wb_valid  = 1'b0;
    st_wr_en  = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        snp_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_LOOKUP:  tag_rd_en = 1'b1;
      ST_COMPARE: proto_err = w_proto;
      ST_WB:      wb_valid  = 1'b1;
      ST_UPDATE:  st_wr_en  = r_change;
      ST_RESP:    rsp_valid = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= SNP_READ;
      r_line      <= '0;
      r_way       <= '0;
      r_new_state <= MESI_M;
      r_result    <= RSP_HIT;
      r_change    <= 1'b0;
      r_hit_cnt   <= '0;
      r_hitm_cnt  <= '0;
      r_nohit_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= snoop_op_t'(snp_op);
        r_line <= snp_addr[31:LINE_OFS];
      end
      if (r_state == ST_COMPARE) begin
        r_way       <= w_hit_way;
        r_new_state <= w_new_state;
        r_result    <= w_result;
        r_change    <= w_change;
      end
      // Statistics count on the response handshake and saturate at all-ones.
      if (r_state == ST_RESP && rsp_ready) begin
        case (r_result)
          RSP_HIT:  if (r_hit_cnt   != '1) r_hit_cnt   <= r_hit_cnt   + CNT_W'(1);
          RSP_HITM: if (r_hitm_cnt  != '1) r_hitm_cnt  <= r_hitm_cnt  + CNT_W'(1);
          default:  if (r_nohit_cnt != '1) r_nohit_cnt <= r_nohit_cnt + CNT_W'(1);
        endcase
      end
    end
  end

  assign tag_rd_set  = w_set;
  assign st_wr_set   = w_set;
  assign st_wr_way   = r_way;
  assign st_wr_state = r_new_state;
  assign wb_addr     = {r_line, {LINE_OFS{1'b0}}};
  assign wb_way      = r_way;
  assign rsp_result  = r_result;
  assign hit_cnt     = r_hit_cnt;
  assign hitm_cnt    = r_hitm_cnt;
  assign nohit_cnt   = r_nohit_cnt;

endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
- Responds to bus operations snooped from other processors against the L1 data cache (8-way, 16K sets, MESI).
- For each snoop it looks up the tag and MESI state of the addressed set and reports HIT, HITM or NOHIT.
- On HITM it requests a writeback of the Modified line, then downgrades or invalidates the line.
- It is the responder counterpart of the controller's own bus-request path; it does not own the tag array and accesses it through a read port and a state-write port.

Parameters:
- D_WAYS, 8, data-cache associativity
- SETS, 16384, sets per way; set index = addr[19:6]
- TAG_WIDTH, 12, tag = addr[31:20]
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- snp_valid  in  1  snoop request valid
- snp_ready  out  1  high only in IDLE
- snp_op  in  2  snoop_op_t: READ=0, WRITE=1, RWIM=2, INVALIDATE=3
- snp_addr  in  32  snooped physical address
- tag_rd_en  out  1  tag/state read strobe; data returns next cycle
- tag_rd_set  out  14  set to read
- tag_rd_tag  in  D_WAYS*TAG_WIDTH  way i at [i*12 +: 12]
- tag_rd_state  in  D_WAYS*2  mesi_state_t per way, M=0, E=1, S=2, I=3
- st_wr_en  out  1  one-cycle state write strobe
- st_wr_set  out  14  set to write
- st_wr_way  out  3  way to write
- st_wr_state  out  2  new MESI state
- wb_valid  out  1  writeback request for the Modified line
- wb_ready  in  1  writeback accepted
- wb_addr  out  32  line-aligned address, {tag, set, 6'b0}
- wb_way  out  3  way holding the data
- rsp_valid  out  1  snoop result valid
- rsp_ready  in  1  result consumed
- rsp_result  out  2  snoop_rsp_t: HIT=0, HITM=1, NOHIT=2
- busy  out  1  not IDLE; the controller must not modify st for this set while busy
- proto_err  out  1  one-cycle pulse on an illegal state for the snooped op
- hit_cnt, hitm_cnt, nohit_cnt  out  CNT_W each  saturating statistics counters

Behaviour:
- Reset: FSM goes to IDLE. snp_ready=1; all other outputs and counters are 0; any in-flight snoop is discarded with no st_wr and no rsp. This applies to reset asserted in any state.
- FSM states and transitions:
  - IDLE: on snp_valid&&snp_ready, latch op and addr, go to LOOKUP.
  - LOOKUP: tag_rd_en=1 for exactly one cycle, tag_rd_set=addr[19:6], go to COMPARE.
  - COMPARE: a way hits when tag matches and state!=I. With multiple hits, the lowest way index wins. Compute result and next state. Go to WB if a writeback is needed, else to UPDATE.
  - WB: wb_valid held high with stable wb_addr/wb_way until wb_ready; then go to UPDATE.
  - UPDATE: st_wr_en=1 for one cycle only if the state changes; go to RESP.
  - RESP: rsp_valid held with a stable result until rsp_ready; return to IDLE the same cycle rsp_ready is seen.
- Latency without writeback: accept at cycle 0, rsp_valid at cycle 4. Each wb_ready stall cycle adds one cycle.
- Per-op rules:
  - READ: M -> S with WB, HITM. E -> S, HIT. S stays S, HIT. Miss gives NOHIT.
  - RWIM: M -> I with WB, HITM. E or S -> I, HIT. Miss gives NOHIT.
  - INVALIDATE: S -> I, HIT. E or M: no change, HIT, proto_err pulse in COMPARE. Miss gives NOHIT.
  - WRITE: always NOHIT, no state change. A valid hit pulses proto_err.
- Counters increment once per snoop, on the rsp handshake. At all-ones they hold.
- rsp_valid and wb_valid are never high simultaneously.
- A new snoop can be accepted no earlier than the cycle after the rsp handshake.

Decomposition:
- Add to pkg_cache: snoop_op_t and snoop_rsp_t enums.
- Reuse from pkg_cache: mesi_state_t, TAG_WIDTH, d_ways, sets.
- Sub-module snoop_way_match: combinational priority hit detector. Inputs are the tag/state vectors and a tag; outputs are hit, way and state.

Test Plan:
- READ to 0x12345678 (set 0x1159, tag 0x123), way 5 in S -> NOHIT? no: HIT; no st_wr; rsp_valid at cycle 4; hit_cnt=1.
- READ to the same address, way 2 in M -> wb_valid with wb_addr=0x12345640, wb_way=2. Hold wb_ready low 3 cycles: wb_valid stays stable. Then st_wr way 2 to S, result HITM, hitm_cnt=1.
- RWIM, way 0 in E and way 3 also matching in S -> way 0 wins; st_wr way 0 to I; result HIT.
- INVALIDATE on a line in E -> proto_err pulses once; no st_wr; result HIT. WRITE to a missing address -> NOHIT; nohit_cnt increments.
- Reset asserted during WB -> next cycle: IDLE, snp_ready=1, wb_valid=0, counters 0, no st_wr or rsp ever emitted for that snoop.
- rsp_ready held low 10 cycles -> rsp_valid and result stable; snp_ready=0 throughout; a new snoop is accepted the cycle after the handshake.
